fifo2axi: RTL and testbench

FIFO2AXI -- requirements
Module: fifo2axi

---
 rtl/fifo2axi.sv | 166 ++++++++++++++++
 tb/tb_fifo2axi.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo2axi.sv
// FIFO to AXI4 write master: streams a 2-D frame (width x height, line stride)
// from a first-word-fall-through FIFO as INCR bursts, one burst in flight.
module fifo2axi #(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_blk_en,
   input  logic [10:0]           cfg_img_width,
   input  logic [10:0]           cfg_img_height,
   input  logic [10:0]           cfg_stride,
   input  logic [31:0]           cfg_map_ba,
   input  logic [7:0]            cfg_max_burst_length,
   input  logic                  cfg_reverse_pixel,
   input  logic [63:0]           fifo_data,
   input  logic [ADDR_WIDTH-1:0] fifo_words_used,
   input  logic                  fifo_full,
   input  logic                  fifo_empty,
   output logic                  fifo_pop,
   output logic [31:0]           awaddr,
   output logic [7:0]            awlen,
   output logic [1:0]            awburst,
   output logic [2:0]            awsize,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [63:0]           wdata,
   output logic [7:0]            wstrb,
   output logic                  wlast,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready,
   output logic                  sts_done,
   output logic                  sts_err
);

   typedef enum logic [2:0] {IDLE, WAIT, ADDR, DATA, RESP, DONE} state_t;

   state_t      state;
   logic        en_d, start, rev, line_end;
   logic [10:0] line_cnt;
   logic [7:0]  beat_cnt, line_beats, blen, blen_c, mb, wcnt, beats_left;
   logic [31:0] line_adv, fill, burst_bytes;

   assign start       = cfg_blk_en & ~en_d;
   assign mb          = (cfg_max_burst_length == 8'd0) ? 8'd1 : cfg_max_burst_length;
   assign blen_c      = (beat_cnt < mb) ? beat_cnt : mb;
   // full flag extends the word count so a completely full FIFO still reads as depth
   assign fill        = 32'({fifo_full, fifo_words_used});
   assign beats_left  = beat_cnt - blen;
   assign line_end    = (beats_left == 8'd0);
   assign burst_bytes = {21'd0, blen, 3'd0};

   assign awburst  = 2'd1;
   assign awsize   = 3'd3;
   assign wstrb    = 8'hFF;
   assign fifo_pop = wvalid & wready & ~fifo_empty;

   always_comb begin
      wdata = fifo_data;
      if (rev)
         for (int i = 0; i < 8; i++) wdata[8*i +: 8] = fifo_data[8*(7-i) +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         en_d       <= 1'b0;
         line_cnt   <= '0;
         beat_cnt   <= '0;
         line_beats <= '0;
         line_adv   <= '0;
         blen       <= '0;
         wcnt       <= '0;
         rev        <= 1'b0;
         awaddr     <= '0;
         awlen      <= '0;
         awvalid    <= 1'b0;
         wvalid     <= 1'b0;
         wlast      <= 1'b0;
         bready     <= 1'b0;
         sts_done   <= 1'b0;
         sts_err    <= 1'b0;
      end else begin
         en_d <= cfg_blk_en;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  line_cnt <= cfg_img_height;
                  beat_cnt <= cfg_img_width[10:3];
                  awaddr   <= cfg_map_ba;
                  sts_err  <= 1'b0;
                  if (cfg_img_height == 11'd0) begin
                     state    <= DONE;
                     sts_done <= 1'b1;
                  end else begin
                     state    <= WAIT;
                     sts_done <= 1'b0;
                  end
               end
            end
            WAIT: begin
               if (!cfg_blk_en) begin
                  state <= IDLE;
               end else if (fill >= 32'(blen_c)) begin
                  // geometry is captured per burst so mid-burst cfg changes are ignored
                  state      <= ADDR;
                  awvalid    <= 1'b1;
                  awlen      <= blen_c - 8'd1;
                  blen       <= blen_c;
                  line_beats <= cfg_img_width[10:3];
                  line_adv   <= 32'(cfg_stride) - 32'(cfg_img_width);
                  rev        <= cfg_reverse_pixel;
               end
            end
            ADDR: begin
               if (awready) begin
                  state   <= DATA;
                  awvalid <= 1'b0;
                  wvalid  <= 1'b1;
                  wlast   <= (blen == 8'd1);
                  wcnt    <= 8'd0;
               end
            end
            DATA: begin
               if (wready) begin
                  if (wlast) begin
                     state  <= RESP;
                     wvalid <= 1'b0;
                     wlast  <= 1'b0;
                     bready <= 1'b1;
                  end else begin
                     wcnt  <= wcnt + 8'd1;
                     wlast <= (wcnt + 8'd2 == blen);
                  end
               end
            end
            RESP: begin
               if (bvalid) begin
                  bready  <= 1'b0;
                  sts_err <= sts_err | (bresp != 2'b00);
                  if (line_end) begin
                     awaddr   <= awaddr + burst_bytes + line_adv;
                     beat_cnt <= line_beats;
                     line_cnt <= line_cnt - 11'd1;
                  end else begin
                     awaddr   <= awaddr + burst_bytes;
                     beat_cnt <= beats_left;
                  end
                  if (line_end && line_cnt == 11'd1) begin
                     state    <= DONE;
                     sts_done <= 1'b1;
                  end else if (!cfg_blk_en) begin
                     state <= IDLE;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo2axi.sv
// Directed bench for fifo2axi: FIFO + AXI slave models, a frame-level reference
// model of expected bursts/beats, and a per-cycle compare process.
module tb_fifo2axi;
   localparam int AW = 5;

   typedef struct {logic [31:0] a; logic [7:0] l;} aw_t;
   typedef struct {logic [63:0] d; logic last;} w_t;

   logic clk = 1'b0, rst = 1'b1;
   logic cfg_blk_en = 1'b0, cfg_reverse_pixel = 1'b0;
   logic [10:0] cfg_img_width = '0, cfg_img_height = '0, cfg_stride = '0;
   logic [31:0] cfg_map_ba = '0;
   logic [7:0]  cfg_max_burst_length = '0;
   logic [63:0] fifo_data;
   logic [AW-1:0] fifo_words_used;
   logic fifo_full, fifo_empty, fifo_pop;
   logic [31:0] awaddr;
   logic [7:0]  awlen, wstrb;
   logic [1:0]  awburst, bresp = 2'b00;
   logic [2:0]  awsize;
   logic awvalid, awready = 1'b1, wlast, wvalid, wready = 1'b1, bvalid = 1'b0, bready;
   logic [63:0] wdata;
   logic sts_done, sts_err;

   fifo2axi #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .cfg_blk_en(cfg_blk_en), .cfg_img_width(cfg_img_width),
      .cfg_img_height(cfg_img_height), .cfg_stride(cfg_stride), .cfg_map_ba(cfg_map_ba),
      .cfg_max_burst_length(cfg_max_burst_length), .cfg_reverse_pixel(cfg_reverse_pixel),
      .fifo_data(fifo_data), .fifo_words_used(fifo_words_used), .fifo_full(fifo_full),
      .fifo_empty(fifo_empty), .fifo_pop(fifo_pop), .awaddr(awaddr), .awlen(awlen),
      .awburst(awburst), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready), .sts_done(sts_done), .sts_err(sts_err));

   always #5 clk = ~clk;

   // FIFO model: src[rd_ptr .. avail-1] is the current content
   logic [63:0] src [0:1023];
   int avail = 0, rd_ptr = 0, used;
   always @(posedge clk) if (fifo_pop) rd_ptr <= rd_ptr + 1;
   always_comb begin
      used            = avail - rd_ptr;
      fifo_words_used = used[AW-1:0];
      fifo_full       = (used >= (1 << AW));
      fifo_empty      = (used == 0);
      fifo_data       = (used > 0) ? src[rd_ptr % 1024] : 64'd0;
   end

   int nvec = 0, nfail = 0, b_cnt = 0, beat_no = 0, base = 0;
   bit check_en = 1'b1, aw_slow = 1'b0, w_toggle = 1'b0, err_first = 1'b0;
   aw_t exp_aw[$], aw_log[$];
   w_t  exp_w[$];
   int  wl_idx[$];
   logic [63:0] wd_log[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] brev(input logic [63:0] d);
      return {<<8{d}};
   endfunction

   // frame-level reference: walk lines and chop each into bursts of at most mb beats
   task automatic build_model(input int w, h, st, input logic [31:0] ba, input int mb,
                              input bit rv, input int first);
      int k = first, mbe = (mb == 0) ? 1 : mb;
      for (int l = 0; l < h; l++) begin
         logic [31:0] addr = ba + 32'(l * st);
         int rem = w / 8;
         while (rem > 0) begin
            int b = (rem < mbe) ? rem : mbe;
            exp_aw.push_back('{addr, 8'(b - 1)});
            for (int j = 0; j < b; j++) begin
               exp_w.push_back('{rv ? brev(src[k % 1024]) : src[k % 1024], (j == b - 1)});
               k++;
            end
            addr += 32'(b * 8);
            rem -= b;
         end
      end
   endtask

   task automatic setup(input int w, h, st, input logic [31:0] ba, input int mb, input bit rv,
                        input int nw, nrel, input bit same, input logic [63:0] pat);
      cfg_img_width = 11'(w); cfg_img_height = 11'(h); cfg_stride = 11'(st);
      cfg_map_ba = ba; cfg_max_burst_length = 8'(mb); cfg_reverse_pixel = rv;
      base = rd_ptr;
      for (int i = 0; i < nw; i++)
         src[(base + i) % 1024] = same ? pat : {32'(base + i), ~32'(base + i)};
      exp_aw.delete(); exp_w.delete();
      build_model(w, h, st, ba, mb, rv, base);
      aw_log.delete(); wl_idx.delete(); wd_log.delete();
      b_cnt = 0; beat_no = 0;
      avail = base + nrel;
   endtask

   task automatic start_frame();
      @(negedge clk); cfg_blk_en = 1'b0;
      @(negedge clk); cfg_blk_en = 1'b1;
      @(negedge clk); #3;
      chk("aw_latency", 64'(awvalid), 64'd0);
      chk("start_done_clr", 64'(sts_done), 64'd0);
      chk("start_err_clr", 64'(sts_err), 64'd0);
   endtask

   task automatic wait_done();
      int i;
      for (i = 0; i < 400; i++) begin
         @(negedge clk); #3;
         if (sts_done) break;
      end
      if (i == 400) chk("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic frame_end();
      chk("aw_left", 64'(exp_aw.size()), 64'd0);
      chk("w_left", 64'(exp_w.size()), 64'd0);
      chk("sts_done", 64'(sts_done), 64'd1);
   endtask

   task automatic slave_loop();
      forever begin
         @(negedge clk);
         awready = aw_slow ? ~awready : 1'b1;
         wready  = w_toggle ? ~wready : 1'b1;
         bvalid  = bready;
         bresp   = (err_first && b_cnt == 0) ? 2'b10 : 2'b00;
      end
   endtask

   task automatic compare_loop();
      logic aw_stall = 1'b0, w_stall = 1'b0, last_hs = 1'b0;
      logic [31:0] p_addr = '0;
      logic [7:0]  p_len = '0;
      logic [63:0] p_wdata = '0;
      aw_t a;
      w_t  w;
      forever begin
         @(negedge clk); #2;
         if (check_en) begin
            chk("pop", 64'(fifo_pop), 64'(wvalid & wready));
            if (fifo_empty) chk("pop_empty", 64'(fifo_pop), 64'd0);
            if (last_hs) chk("bready_lat", 64'(bready), 64'd1);
            if (awvalid) begin
               if (aw_stall) begin
                  chk("aw_hold_addr", 64'(awaddr), 64'(p_addr));
                  chk("aw_hold_len", 64'(awlen), 64'(p_len));
               end
               if (awready) begin
                  if (exp_aw.size() == 0) chk("aw_extra", 64'd1, 64'd0);
                  else begin
                     a = exp_aw.pop_front();
                     chk("awaddr", 64'(awaddr), 64'(a.a));
                     chk("awlen", 64'(awlen), 64'(a.l));
                     chk("awburst_size", 64'({awburst, awsize}), 64'({2'd1, 3'd3}));
                     aw_log.push_back('{awaddr, awlen});
                  end
               end
            end
            if (wvalid) begin
               chk("wstrb", 64'(wstrb), 64'hFF);
               if (w_stall) chk("wdata_hold", wdata, p_wdata);
               if (wready) begin
                  beat_no++;
                  if (exp_w.size() == 0) chk("w_extra", 64'd1, 64'd0);
                  else begin
                     w = exp_w.pop_front();
                     chk("wdata", wdata, w.d);
                     chk("wlast", 64'(wlast), 64'(w.last));
                  end
                  wd_log.push_back(wdata);
                  if (wlast) wl_idx.push_back(beat_no);
               end
            end
            if (bvalid & bready) b_cnt++;
         end
         aw_stall = awvalid & ~awready;
         w_stall  = wvalid & ~wready;
         last_hs  = wvalid & wready & wlast;
         p_addr = awaddr; p_len = awlen; p_wdata = wdata;
      end
   endtask

   initial begin
      int i;
      fork
         slave_loop();
         compare_loop();
      join_none

      // reset state
      repeat (3) @(negedge clk);
      #3;
      chk("rst_awvalid", 64'(awvalid), 64'd0);
      chk("rst_wvalid", 64'(wvalid), 64'd0);
      chk("rst_wlast", 64'(wlast), 64'd0);
      chk("rst_bready", 64'(bready), 64'd0);
      chk("rst_pop", 64'(fifo_pop), 64'd0);
      chk("rst_sts", 64'({sts_done, sts_err}), 64'd0);
      chk("rst_awaddr", 64'(awaddr), 64'd0);
      chk("rst_awlen", 64'(awlen), 64'd0);
      rst = 1'b0;

      // two full lines, two max-size bursts
      setup(64, 2, 128, 32'h1000, 8, 0, 16, 16, 0, 64'd0);
      start_frame();
      wait_done();
      frame_end();
      chk("t1_nbursts", 64'(aw_log.size()), 64'd2);
      if (aw_log.size() >= 2) begin
         chk("t1_aw0", 64'({aw_log[0].a, aw_log[0].l}), {24'd0, 32'h1000, 8'd7});
         chk("t1_aw1", 64'({aw_log[1].a, aw_log[1].l}), {24'd0, 32'h1080, 8'd7});
      end
      chk("t1_pops", 64'(rd_ptr - base), 64'd16);

      // line split into 4,4,2
      setup(80, 1, 80, 32'h1000, 4, 0, 10, 10, 0, 64'd0);
      start_frame();
      wait_done();
      frame_end();
      chk("t2_nbursts", 64'(aw_log.size()), 64'd3);
      if (aw_log.size() >= 3) begin
         chk("t2_aw0", 64'({aw_log[0].a, aw_log[0].l}), {24'd0, 32'h1000, 8'd3});
         chk("t2_aw1", 64'({aw_log[1].a, aw_log[1].l}), {24'd0, 32'h1020, 8'd3});
         chk("t2_aw2", 64'({aw_log[2].a, aw_log[2].l}), {24'd0, 32'h1040, 8'd1});
      end
      chk("t2_nlast", 64'(wl_idx.size()), 64'd3);
      if (wl_idx.size() >= 3)
         chk("t2_last_idx", 64'({8'(wl_idx[0]), 8'(wl_idx[1]), 8'(wl_idx[2])}), 64'h04080A);

      // FIFO short by one word: no AW until the 4th word lands
      setup(32, 1, 32, 32'h2000, 4, 0, 4, 3, 0, 64'd0);
      start_frame();
      for (i = 0; i < 6; i++) begin
         @(negedge clk); #3;
         chk("t3_no_aw", 64'(awvalid), 64'd0);
         chk("t3_no_pop", 64'(rd_ptr - base), 64'd0);
      end
      avail = avail + 1;
      wait_done();
      frame_end();
      chk("t3_pops", 64'(rd_ptr - base), 64'd4);

      // byte reverse with stalled W and AW channels
      aw_slow = 1'b1; w_toggle = 1'b1;
      setup(64, 1, 64, 32'h3000, 8, 1, 8, 8, 1, 64'h0102030405060708);
      start_frame();
      wait_done();
      frame_end();
      chk("t4_nbeats", 64'(wd_log.size()), 64'd8);
      if (wd_log.size() >= 1) chk("t4_rev", wd_log[0], 64'h0807060504030201);
      chk("t4_pops", 64'(rd_ptr - base), 64'd8);
      aw_slow = 1'b0; w_toggle = 1'b0;

      // SLVERR on first burst is sticky to frame end, new start clears it
      err_first = 1'b1;
      setup(64, 2, 64, 32'h4000, 8, 0, 16, 16, 0, 64'd0);
      start_frame();
      wait_done();
      frame_end();
      chk("t5_err", 64'(sts_err), 64'd1);
      err_first = 1'b0;
      setup(64, 1, 64, 32'h5000, 8, 0, 8, 8, 0, 64'd0);
      start_frame();
      wait_done();
      frame_end();
      chk("t5_err_clr", 64'(sts_err), 64'd0);

      // enable dropped during DATA: burst completes, then IDLE without done
      setup(64, 2, 128, 32'h6000, 8, 0, 16, 16, 0, 64'd0);
      start_frame();
      for (i = 0; i < 50; i++) begin
         @(negedge clk); #3;
         if (wvalid) break;
      end
      if (i == 50) chk("t6_w_timeout", 64'd0, 64'd1);
      cfg_blk_en = 1'b0;
      for (i = 0; i < 50; i++) begin
         @(negedge clk); #3;
         if (b_cnt == 1) break;
      end
      if (i == 50) chk("t6_b_timeout", 64'd0, 64'd1);
      repeat (3) begin
         @(negedge clk); #3;
         chk("t6_no_aw", 64'(awvalid), 64'd0);
      end
      chk("t6_done", 64'(sts_done), 64'd0);
      chk("t6_aw_left", 64'(exp_aw.size()), 64'd1);
      chk("t6_w_left", 64'(exp_w.size()), 64'd8);
      chk("t6_nlast", 64'(wl_idx.size()), 64'd1);
      exp_aw.delete(); exp_w.delete();
      avail = rd_ptr;

      // reset in the middle of DATA
      setup(64, 1, 64, 32'h7000, 8, 0, 8, 8, 0, 64'd0);
      start_frame();
      for (i = 0; i < 50; i++) begin
         @(negedge clk); #3;
         if (wvalid) break;
      end
      if (i == 50) chk("t7_w_timeout", 64'd0, 64'd1);
      check_en = 1'b0;
      rst = 1'b1;
      cfg_blk_en = 1'b0;
      @(negedge clk); #3;
      chk("t7_valids", 64'({awvalid, wvalid, wlast, bready, fifo_pop}), 64'd0);
      chk("t7_sts", 64'({sts_done, sts_err}), 64'd0);
      chk("t7_aw", 64'({awaddr, awlen}), 64'd0);
      rst = 1'b0;
      exp_aw.delete(); exp_w.delete();
      avail = rd_ptr;
      @(negedge clk);
      check_en = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
